// File: rtl/wireshark_onchip_memory_dp_pkg.sv
// Shared types and helpers for the WireShark dual-port on-chip memory.
// WIRESHARK_OCM_OUTREG_EN selects the read latency (1 without, 2 with).
package wireshark_ocm_pkg;

   localparam int OCM_MAX_W = 512;
   typedef logic [OCM_MAX_W-1:0]   ocm_word_t;
   typedef logic [OCM_MAX_W/8-1:0] ocm_be_t;

`ifdef WIRESHARK_OCM_OUTREG_EN
   localparam int OCM_RD_LAT = 2;
`else
   localparam int OCM_RD_LAT = 1;
`endif

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   // Callers widen to ocm_word_t and truncate the result back to DATA_W.
   function automatic ocm_word_t byte_merge(input ocm_word_t old_w, input ocm_word_t new_w,
                                            input ocm_be_t be);
      ocm_word_t r;
      r = old_w;
      for (int i = 0; i < OCM_MAX_W/8; i++)
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/wireshark_onchip_memory_dp_if.sv
// One Avalon-MM slave port of the dual-port on-chip memory.
interface wireshark_onchip_memory_dp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   import wireshark_ocm_pkg::*;

   localparam int BE_W = be_width(DATA_W);

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );

endinterface

// File: rtl/wireshark_onchip_memory_dp_tdp_ram.sv
// Inferred true-dual-port byte-enabled RAM, no reset, old-data on read.
module wireshark_tdp_ram
   import wireshark_ocm_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 4096,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int BE_W   = be_width(DATA_W)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we_a,
   input  logic [BE_W-1:0]   be_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wd_a,
   output logic [DATA_W-1:0] q_a,
   input  logic              we_b,
   input  logic [BE_W-1:0]   be_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wd_b,
   output logic [DATA_W-1:0] q_b
);

   logic [BE_W-1:0][7:0] mem [DEPTH];

   // The top masks overlapping s2 bytes, so the two write ports never
   // hit the same byte in one cycle and their order here is irrelevant.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (we_a && be_a[i]) mem[addr_a][i] <= wd_a[8*i +: 8];
            if (we_b && be_b[i]) mem[addr_b][i] <= wd_b[8*i +: 8];
         end
         q_a <= mem[addr_a];
         q_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/wireshark_onchip_memory_dp.sv
// Dual-port on-chip memory: arbitration, forwarding, valid pipeline, stall.
// WIRESHARK_OCM_OUTREG_EN adds an output register stage on both ports (L = 2).
module wireshark_onchip_memory_dp
   import wireshark_ocm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clken,
   input  logic reset_req,
   input  logic freeze,
   wireshark_onchip_memory_dp_if.slave s1,
   wireshark_onchip_memory_dp_if.slave s2
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BE_W   = be_width(DATA_W);

   logic                   ce, wait_r, ww_coll;
   logic [1:0]             cs, rd, wr, wr_acc, wr_eff, rd_acc, rdv;
   logic [1:0][ADDR_W-1:0] addr;
   logic [1:0][BE_W-1:0]   be, be_eff;
   logic [1:0][DATA_W-1:0] wdata, ram_q, rdata;

   assign ce     = clken & ~reset_req;
   assign wait_r = reset | ~ce;

   assign cs    = {s2.chipselect, s1.chipselect};
   assign rd    = {s2.read,       s1.read};
   assign wr    = {s2.write,      s1.write};
   assign addr  = {s2.address,    s1.address};
   assign be    = {s2.byteenable, s1.byteenable};
   assign wdata = {s2.writedata,  s1.writedata};

   assign s1.waitrequest   = wait_r;
   assign s2.waitrequest   = wait_r;
   assign s1.readdatavalid = rdv[0];
   assign s2.readdatavalid = rdv[1];
   assign s1.readdata      = rdata[0];
   assign s2.readdata      = rdata[1];

   // s1 owns every byte it enables on a same-address write-write collision.
   assign ww_coll   = wr_eff[0] & wr_eff[1] & (addr[0] == addr[1]);
   assign be_eff[0] = be[0];
   assign be_eff[1] = ww_coll ? (be[1] & ~be[0]) : be[1];

   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam int O = 1 - p;

      logic [OCM_RD_LAT:1] vld_pipe;
      logic [BE_W-1:0]     fwd_be, fwd_be_q;
      logic [DATA_W-1:0]   fwd_d_q, merged, resp, hold;

      assign wr_acc[p] = cs[p] & wr[p] & ~wait_r;
      assign rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~wait_r;
      assign wr_eff[p] = wr_acc[p] & ~freeze;

      // RAM returns old data on a mixed-port hit; patch in the other port's write.
      assign fwd_be = (wr_eff[O] && addr[O] == addr[p]) ? be_eff[O] : '0;

      always_ff @(posedge clk) begin
         if (!wait_r) begin
            fwd_be_q <= fwd_be;
            fwd_d_q  <= wdata[O];
         end
      end

      assign merged = DATA_W'(byte_merge(ocm_word_t'(ram_q[p]), ocm_word_t'(fwd_d_q),
                                         ocm_be_t'(fwd_be_q)));

      always_ff @(posedge clk) begin
         if (reset) begin
            vld_pipe <= '0;
         end else if (ce) begin
            vld_pipe[1] <= rd_acc[p];
            for (int i = 2; i <= OCM_RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
         end
      end

`ifdef WIRESHARK_OCM_OUTREG_EN
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) begin
         if (!wait_r) out_q <= merged;
      end
      assign resp = out_q;
`else
      assign resp = merged;
`endif

      // Stalled or resetting cycles hide the head response without losing it.
      assign rdv[p] = vld_pipe[OCM_RD_LAT] & ~wait_r;

      always_ff @(posedge clk) begin
         if (reset)       hold <= '0;
         else if (rdv[p]) hold <= resp;
      end

      assign rdata[p] = rdv[p] ? resp : hold;
   end

   wireshark_tdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk    (clk),
      .en     (~wait_r),
      .we_a   (wr_eff[0]),
      .be_a   (be_eff[0]),
      .addr_a (addr[0]),
      .wd_a   (wdata[0]),
      .q_a    (ram_q[0]),
      .we_b   (wr_eff[1]),
      .be_b   (be_eff[1]),
      .addr_b (addr[1]),
      .wd_b   (wdata[1]),
      .q_b    (ram_q[1])
   );

endmodule

// File: tb/tb_wireshark_onchip_memory_dp.sv
// Scoreboard bench for wireshark_onchip_memory_dp (either latency build).
module tb_wireshark_onchip_memory_dp;

`ifdef WIRESHARK_OCM_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset, clken, reset_req, freeze;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   armed = 1'b0;
   logic rst_seen = 1'b0;
   logic [31:0] last [2];
   exp_t sb [$];

   wireshark_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(12)) m1 ();
   wireshark_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(12)) m2 ();

   wireshark_onchip_memory_dp #(.DATA_W(32), .DEPTH(4096)) dut (
      .clk       (clk),
      .reset     (reset),
      .clken     (clken),
      .reset_req (reset_req),
      .freeze    (freeze),
      .s1        (m1),
      .s2        (m2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   // Response monitor: every valid must match the oldest expectation for its
   // port, at its due cycle; otherwise readdata must hold its last value.
   always @(negedge clk) begin
      if (armed) begin
         for (int p = 0; p < 2; p++) begin
            logic        v;
            logic [31:0] rdat;
            int          idx;
            v    = (p == 0) ? m1.readdatavalid : m2.readdatavalid;
            rdat = (p == 0) ? m1.readdata      : m2.readdata;
            if (rst_seen) last[p] = '0;
            n_vec++;
            if (v) begin
               idx = -1;
               for (int i = 0; i < sb.size(); i++)
                  if (idx < 0 && sb[i].port == p) idx = i;
               if (idx < 0) begin
                  n_err++;
                  $display("FAIL resp_unexpected s%0d: got valid data %h at cycle %0d, want no response",
                           p + 1, rdat, cyc);
               end else begin
                  if (rdat !== sb[idx].data || cyc != sb[idx].due) begin
                     n_err++;
                     $display("FAIL resp s%0d: got %h at cycle %0d, want %h at cycle %0d",
                              p + 1, rdat, cyc, sb[idx].data, sb[idx].due);
                  end
                  sb.delete(idx);
               end
               last[p] = rdat;
            end else if (rdat !== last[p]) begin
               n_err++;
               $display("FAIL hold s%0d: got readdata %h, want held %h", p + 1, rdat, last[p]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int p, input bit r, input bit w, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be);
      if (p == 0) begin
         m1.chipselect = r | w; m1.read = r; m1.write = w;
         m1.address = a; m1.writedata = d; m1.byteenable = be;
      end else begin
         m2.chipselect = r | w; m2.read = r; m2.write = w;
         m2.address = a; m2.writedata = d; m2.byteenable = be;
      end
   endtask

   task automatic idle();
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 0, 0, '0, '0, '0);
   endtask

   // Called while the request is driven, before the accepting edge.
   task automatic push(input int p, input logic [31:0] d, input int extra);
      exp_t e;
      e.port = p; e.data = d; e.due = cyc + L + extra;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d responses outstanding, want 0", sb.size());
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
      idle();
      tick();
      @(negedge clk);
      n_vec += 6;
      if (m1.waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait s1: got %b want 1", m1.waitrequest); end
      if (m2.waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait s2: got %b want 1", m2.waitrequest); end
      if (m1.readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv s1: got %b want 0", m1.readdatavalid); end
      if (m2.readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv s2: got %b want 0", m2.readdatavalid); end
      if (m1.readdata !== 32'h0) begin n_err++; $display("FAIL reset_data s1: got %h want 0", m1.readdata); end
      if (m2.readdata !== 32'h0) begin n_err++; $display("FAIL reset_data s2: got %h want 0", m2.readdata); end
      last[0] = '0; last[1] = '0;
      armed = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_vec += 2;
      if (m1.waitrequest !== 1'b0) begin n_err++; $display("FAIL run_wait s1: got %b want 0", m1.waitrequest); end
      if (m2.waitrequest !== 1'b0) begin n_err++; $display("FAIL run_wait s2: got %b want 0", m2.waitrequest); end
      tick();
   endtask

   task automatic test_basic();
      drv(0, 0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      n_vec++;
      if (m1.waitrequest !== 1'b0) begin n_err++; $display("FAIL basic_wait: got %b want 0", m1.waitrequest); end
      tick();
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 1, 0, 12'h010, '0, 4'hF);
      push(1, 32'hDEADBEEF, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_ww_collision();
      drv(0, 0, 1, 12'h020, 32'h11111111, 4'h3);
      drv(1, 0, 1, 12'h020, 32'h22222222, 4'hF);
      tick();
      drv(0, 1, 0, 12'h020, '0, 4'hF); push(0, 32'h22221111, 0);
      drv(1, 1, 0, 12'h020, '0, 4'hF); push(1, 32'h22221111, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_rdw();
      drv(0, 0, 1, 12'h030, 32'hAAAAAAAA, 4'hF);
      tick();
      drv(0, 0, 1, 12'h030, 32'h00000055, 4'h1);
      drv(1, 1, 0, 12'h030, '0, 4'hF); push(1, 32'hAAAAAA55, 0);
      tick();
      drv(0, 1, 0, 12'h030, '0, 4'hF); push(0, 32'hFFFFAA55, 0);
      drv(1, 0, 1, 12'h030, 32'hFFFF0000, 4'hC);
      tick();
      freeze = 1'b1;
      drv(0, 1, 0, 12'h030, '0, 4'hF); push(0, 32'hFFFFAA55, 0);
      drv(1, 0, 1, 12'h030, 32'h00000000, 4'hF);
      tick();
      freeze = 1'b0;
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 1, 0, 12'h030, '0, 4'hF); push(1, 32'hFFFFAA55, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_rw_same_port();
      drv(0, 1, 1, 12'h060, 32'hCAFEF00D, 4'hF);
      tick();
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 1, 0, 12'h060, '0, 4'hF); push(1, 32'hCAFEF00D, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_freeze();
      drv(0, 0, 1, 12'h040, 32'h00000000, 4'hF);
      tick();
      freeze = 1'b1;
      drv(0, 0, 1, 12'h040, 32'h12345678, 4'hF);
      @(negedge clk);
      n_vec++;
      if (m1.waitrequest !== 1'b0) begin n_err++; $display("FAIL freeze_wait: got %b want 0", m1.waitrequest); end
      tick();
      freeze = 1'b0;
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 1, 0, 12'h040, '0, 4'hF); push(1, 32'h00000000, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_stall();
      drv(0, 1, 0, 12'h010, '0, 4'hF); push(0, 32'hDEADBEEF, 3);
      tick();
      idle();
      clken = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_vec += 3;
         if (m1.waitrequest !== 1'b1) begin n_err++; $display("FAIL stall_wait s1: got %b want 1", m1.waitrequest); end
         if (m2.waitrequest !== 1'b1) begin n_err++; $display("FAIL stall_wait s2: got %b want 1", m2.waitrequest); end
         if (m1.readdatavalid !== 1'b0) begin n_err++; $display("FAIL stall_rdv s1: got %b want 0", m1.readdatavalid); end
         tick();
      end
      clken = 1'b1;
      wait_drain();
      drv(1, 1, 0, 12'h020, '0, 4'hF); push(1, 32'h22221111, 1);
      tick();
      idle();
      reset_req = 1'b1;
      @(negedge clk);
      n_vec++;
      if (m2.waitrequest !== 1'b1) begin n_err++; $display("FAIL rstreq_wait s2: got %b want 1", m2.waitrequest); end
      tick();
      reset_req = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_mid_read();
      drv(0, 1, 0, 12'h010, '0, 4'hF);
      tick();
      idle();
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if (m1.readdatavalid !== 1'b0) begin n_err++; $display("FAIL midrst_rdv: got %b want 0", m1.readdatavalid); end
      tick();
      reset = 1'b0;
      repeat (L + 2) begin
         @(negedge clk);
         n_vec += 2;
         if (m1.readdatavalid !== 1'b0) begin n_err++; $display("FAIL postrst_rdv: got %b want 0", m1.readdatavalid); end
         if (m1.readdata !== 32'h0) begin n_err++; $display("FAIL postrst_data: got %h want 0", m1.readdata); end
         tick();
      end
      drv(0, 1, 0, 12'h010, '0, 4'hF); push(0, 32'hDEADBEEF, 0);
      tick();
      idle();
      wait_drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d1 [8];
      logic [31:0] d2 [8];
      for (int i = 0; i < 8; i++) begin
         d1[i] = $urandom;
         d2[i] = $urandom;
         drv(0, 0, 1, 12'(256 + i), d1[i], 4'hF);
         drv(1, 0, 1, 12'(512 + i), d2[i], 4'hF);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drv(0, 1, 0, 12'(512 + i), '0, 4'hF); push(0, d2[i], 0);
         drv(1, 1, 0, 12'(256 + i), '0, 4'hF); push(1, d1[i], 0);
         tick();
      end
      idle();
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ww_collision();
      test_rdw();
      test_rw_same_port();
      test_freeze();
      test_stall();
      test_reset_mid_read();
      test_back_to_back();
      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
